aes256_job_sequencer: RTL and testbench
=======================================

// Module: aes256_job_sequencer
// PURPOSE
//  Shares one AES256_device between NREQ requesters. Arbitrates round-robin and latches the
//  winner's 256-bit key, 128-bit block and direction. Drives the device's 3-beat load protocol.
//  Waits for ctrl_dataOut, then returns the result to the winner on a valid/ready channel.
//  Sits between bus-side job clients and the AES256 core; it is the only block that drives it.
// PARAMETERS
//  NREQ      2    number of requesters (2..4)
//  TIMEOUT   256  max cycles in WAIT before the job is aborted (>=32)
// PORTS
//  clk            in   1          clock; all logic on posedge
//  resetn         in   1          synchronous reset, active-high (1 = reset)
//  req_valid      in   NREQ       job request per requester
//  req_ready      out  NREQ       one-hot accept strobe (at most one bit set)
//  req_key        in   NREQ*256   per-requester key; slice i = [i*256 +: 256]
//  req_data       in   NREQ*128   per-requester plaintext/ciphertext block
//  req_dec        in   NREQ       0 = encrypt, 1 = decrypt
//  rsp_valid      out  NREQ       one-hot response valid to owning requester
//  rsp_ready      in   NREQ       response accept per requester
//  rsp_data       out  128        result block (shared bus, qualified by rsp_valid)
//  rsp_err        out  1          1 = job aborted by timeout; rsp_data = 0
//  dev_inp        out  128        to AES256_device.inp_device
//  dev_ctrl_in    out  1          to AES256_device.ctrl_dataIn
//  dev_mod_en     out  2          to AES256_device.mod_en (10 key, 00 enc, 01 dec)
//  dev_resetn     out  1          to AES256_device.resetn (active-low)
//  dev_out        in   128        from AES256_device.outp_device
//  dev_ctrl_out   in   1          from AES256_device.ctrl_dataOut
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0. req_ready=0 and rsp_valid=0. rsp_data=0 and rsp_err=0.
//   dev_inp=0, dev_ctrl_in=0, dev_mod_en=2'b00, dev_resetn=1, timeout count=0.
//  Reset mid-job drops the job silently. No response is produced for it.
//  FSM: IDLE -> KEY_HI -> KEY_LO -> DATA -> WAIT -> RESP -> IDLE, with WAIT -> ABORT -> RESP.
//  IDLE: if any req_valid, grant the first set bit at or after the rr pointer, wrapping.
//   Pulse req_ready[g] for that cycle and latch key, data, dec and g. Next state = KEY_HI.
//   rr pointer <= g+1 mod NREQ on grant. Requests arriving in other states wait, unacked.
//  KEY_HI: dev_ctrl_in=1, dev_mod_en=10, dev_inp=key[255:128].
//  KEY_LO: dev_ctrl_in=1, dev_mod_en=10, dev_inp=key[127:0].
//  DATA: dev_ctrl_in=1, dev_mod_en={1'b0,dec}, dev_inp=data.
//  The three beats are registered outputs on consecutive cycles, 1 cycle after grant. No gaps.
//  WAIT: dev_ctrl_in=0. The timeout counter increments each cycle.
//   dev_ctrl_out=1 -> capture dev_out into rsp_data, rsp_err=0, go to RESP.
//   Counter reaches TIMEOUT-1 with no dev_ctrl_out -> go to ABORT.
//  ABORT: dev_resetn=0 for exactly 2 cycles, then rsp_data=0, rsp_err=1, go to RESP.
//  RESP: rsp_valid[g]=1 and holds with rsp_data/rsp_err stable until rsp_ready[g]=1.
//   Then return to IDLE. rsp_ready on non-owner bits is ignored.
//  dev_ctrl_out outside WAIT is ignored. If dev_ctrl_out and timeout expiry coincide, success wins.
//  Min latency, grant to rsp_valid: 4 + device latency cycles.
//  One job in flight. Grant-to-grant minimum = job latency + 1 cycle (IDLE re-entry).
// STRUCTURE
//  Package aes256_seq_pkg:
//   state_t enum {IDLE, KEY_HI, KEY_LO, DATA, WAIT, ABORT, RESP}
//   MOD_KEY=2'b10, MOD_ENC=2'b00, MOD_DEC=2'b01, KEY_W=256, BLK_W=128.
//  Sub-module rr_arbiter #(NREQ): req vector + pointer in -> one-hot grant and index out.
//   It is combinational. The sequencer owns the pointer register.
// TESTING
//  1. Encrypt: req0 with key 0f0e..00 repeated twice, data 0400..0100, dec=0.
//     -> beats 10/10/00 on 3 consecutive cycles.
//     -> rsp_valid[0] with device result, rsp_err=0.
//  2. Decrypt: req0 with same key, data 7a584d99febc93ead6b3563cc4ad3a63, dec=1.
//     -> third beat mod_en=01; result returned to req0.
//  3. Both requesters valid continuously for 4 jobs -> grants alternate 0,1,0,1 from reset.
//     -> each rsp_valid goes only to its own requester.
//  4. Device model never raises ctrl_dataOut, TIMEOUT=32.
//     -> dev_resetn low for 2 cycles after 32 WAIT cycles.
//     -> rsp_err=1 and rsp_data=0.
//  5. rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable throughout.
//     -> no new req_ready is issued until the response is accepted.
//  6. Assert resetn during WAIT -> next cycle every output is at its reset value.
//     -> a new request after reset completes normally.

Source files
------------

// File: rtl/aes256_seq_pkg.sv
// Shared types and constants for the AES256 job sequencer.
package aes256_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY_HI,
    KEY_LO,
    DATA,
    WAIT,
    ABORT,
    RESP
  } state_t;

  localparam logic [1:0] MOD_KEY = 2'b10;
  localparam logic [1:0] MOD_ENC = 2'b00;
  localparam logic [1:0] MOD_DEC = 2'b01;
  localparam int KEY_W = 256;
  localparam int BLK_W = 128;

endpackage

// File: rtl/aes256_job_sequencer_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter
  import aes256_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr) + off) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/aes256_job_sequencer.sv
// Shares one AES256 device between NREQ requesters: round-robin grant, 3-beat load,
// bounded wait for the result, and a held response back to the owning requester.
module aes256_job_sequencer
  import aes256_seq_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*KEY_W-1:0] req_key,
  input  logic [NREQ*BLK_W-1:0] req_data,
  input  logic [NREQ-1:0]       req_dec,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [BLK_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [BLK_W-1:0]      dev_inp,
  output logic                  dev_ctrl_in,
  output logic [1:0]            dev_mod_en,
  output logic                  dev_resetn,
  input  logic [BLK_W-1:0]      dev_out,
  input  logic                  dev_ctrl_out
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  state_t            state, state_next;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic [BLK_W-1:0]  key_lo_q;
  logic [BLK_W-1:0]  data_q;
  logic              dec_q;
  logic [CW-1:0]     cnt;
  logic              abort_cnt;

  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     gidx;
  logic              any;
  logic [KEY_W-1:0]  sel_key;

  logic [BLK_W-1:0]  dev_inp_d;
  logic              dev_ctrl_in_d;
  logic [1:0]        dev_mod_en_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign sel_key = req_key[32'(gidx)*KEY_W +: KEY_W];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any) state_next = KEY_HI;
      KEY_HI:  state_next = KEY_LO;
      KEY_LO:  state_next = DATA;
      DATA:    state_next = WAIT;
      // a result on the last counted cycle still beats the timeout
      WAIT: begin
        if (dev_ctrl_out)                 state_next = RESP;
        else if (cnt == CW'(TIMEOUT - 1)) state_next = ABORT;
      end
      ABORT:   if (abort_cnt) state_next = RESP;
      RESP:    if (rsp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (!resetn && state == IDLE) req_ready = grant;
    if (!resetn && state == RESP) rsp_valid[owner] = 1'b1;
  end

  // Device beats are registered, so they are decoded from the state being entered;
  // the high key half comes straight from the requester on the grant cycle.
  always_comb begin
    dev_inp_d     = '0;
    dev_ctrl_in_d = 1'b0;
    dev_mod_en_d  = MOD_ENC;
    case (state_next)
      KEY_HI: begin
        dev_inp_d     = sel_key[KEY_W-1:BLK_W];
        dev_ctrl_in_d = 1'b1;
        dev_mod_en_d  = MOD_KEY;
      end
      KEY_LO: begin
        dev_inp_d     = key_lo_q;
        dev_ctrl_in_d = 1'b1;
        dev_mod_en_d  = MOD_KEY;
      end
      DATA: begin
        dev_inp_d     = data_q;
        dev_ctrl_in_d = 1'b1;
        dev_mod_en_d  = dec_q ? MOD_DEC : MOD_ENC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      key_lo_q    <= '0;
      data_q      <= '0;
      dec_q       <= 1'b0;
      cnt         <= '0;
      abort_cnt   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      dev_inp     <= '0;
      dev_ctrl_in <= 1'b0;
      dev_mod_en  <= MOD_ENC;
      dev_resetn  <= 1'b1;
    end else begin
      state       <= state_next;
      dev_inp     <= dev_inp_d;
      dev_ctrl_in <= dev_ctrl_in_d;
      dev_mod_en  <= dev_mod_en_d;
      dev_resetn  <= (state_next != ABORT);
      cnt         <= (state == WAIT) ? cnt + 1'b1 : '0;
      abort_cnt   <= (state == ABORT) ? ~abort_cnt : 1'b0;
      if (state == IDLE && any) begin
        key_lo_q <= sel_key[BLK_W-1:0];
        data_q   <= req_data[32'(gidx)*BLK_W +: BLK_W];
        dec_q    <= req_dec[gidx];
        owner    <= gidx;
        ptr      <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      if (state == WAIT && dev_ctrl_out) begin
        rsp_data <= dev_out;
        rsp_err  <= 1'b0;
      end else if (state == ABORT && abort_cnt) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes256_job_sequencer.sv
// Self-checking bench for aes256_job_sequencer with a stand-in AES device model.
module tb_aes256_job_sequencer;

  localparam int NREQ = 2;
  localparam int TMO  = 32;

  logic                clk = 1'b0;
  logic                resetn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*256-1:0] req_key;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ-1:0]     req_dec;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [127:0]        rsp_data;
  logic                rsp_err;
  logic [127:0]        dev_inp;
  logic                dev_ctrl_in;
  logic [1:0]          dev_mod_en;
  logic                dev_resetn;
  logic [127:0]        dev_out;
  logic                dev_ctrl_out;

  logic [255:0] key_a  [NREQ];
  logic [127:0] data_a [NREQ];
  logic         dec_a  [NREQ];

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int dev_lat;
  bit dev_mute;

  assign req_key  = {key_a[1], key_a[0]};
  assign req_data = {data_a[1], data_a[0]};
  assign req_dec  = {dec_a[1], dec_a[0]};

  always #5 clk = ~clk;

  aes256_job_sequencer #(
    .NREQ    (NREQ),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .req_data     (req_data),
    .req_dec      (req_dec),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .dev_inp      (dev_inp),
    .dev_ctrl_in  (dev_ctrl_in),
    .dev_mod_en   (dev_mod_en),
    .dev_resetn   (dev_resetn),
    .dev_out      (dev_out),
    .dev_ctrl_out (dev_ctrl_out)
  );

  // Stand-in cipher: order-sensitive mix of the three beats, inverted for decrypt.
  function automatic logic [127:0] dev_func(input logic [127:0] khi, input logic [127:0] klo,
                                            input logic [127:0] d, input logic dec);
    logic [127:0] r;
    r = d ^ khi ^ {klo[63:0], klo[127:64]};
    if (dec) r = ~r;
    return r;
  endfunction

  // Device model: collects three beats, answers dev_lat cycles after the data beat.
  logic [127:0] beat [3];
  int           bc;
  int           cd;
  logic         dec_b;
  always @(posedge clk) begin
    dev_ctrl_out <= 1'b0;
    if (!dev_resetn || resetn) begin
      bc <= 0;
      cd <= 0;
      dev_out <= '0;
    end else begin
      if (cd > 0) begin
        if (cd == 1) begin
          dev_ctrl_out <= 1'b1;
          dev_out <= dev_func(beat[0], beat[1], beat[2], dec_b);
        end
        cd <= cd - 1;
      end
      if (dev_ctrl_in) begin
        beat[bc] <= dev_inp;
        if (bc == 2) begin
          bc    <= 0;
          dec_b <= dev_mod_en[0];
          if (!dev_mute) cd <= dev_lat;
        end else begin
          bc <= bc + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int o = 0; o < NREQ; o++) begin
      int c;
      c = (model_ptr + o) % NREQ;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_err, rsp_data, dev_inp, dev_ctrl_in, dev_mod_en, dev_resetn},
        {2'b00, 2'b00, 1'b0, 128'h0, 128'h0, 1'b0, 2'b00, 1'b1});
  endtask

  task automatic rand_req(input int r);
    for (int w = 0; w < 8; w++) key_a[r][w*32 +: 32] = $urandom();
    for (int w = 0; w < 4; w++) data_a[r][w*32 +: 32] = $urandom();
    dec_a[r] = 1'($urandom_range(0, 1));
  endtask

  // Entered and left on a negedge. One full job against the reference model.
  task automatic run_job(input int lat, input bit mute, input bit drop, input int hold);
    int g, k, rst_at, lows;
    bit seen, tmo;
    logic [NREQ-1:0] oh;
    logic [127:0] xd;
    g = exp_grant(req_valid);
    oh = '0;
    oh[g] = 1'b1;
    tmo = mute || (lat + 1 > TMO);
    xd = tmo ? 128'h0 : dev_func(key_a[g][255:128], key_a[g][127:0], data_a[g], dec_a[g]);
    dev_lat = lat;
    dev_mute = mute;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready != '0) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("grant_seen", 300'(seen), 300'(1));
    chk("grant", 300'(req_ready), 300'(oh));
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    if (drop) req_valid[g] = 1'b0;
    chk("beat_key_hi", {dev_ctrl_in, dev_mod_en, dev_inp}, {1'b1, 2'b10, key_a[g][255:128]});
    @(negedge clk);
    chk("beat_key_lo", {dev_ctrl_in, dev_mod_en, dev_inp}, {1'b1, 2'b10, key_a[g][127:0]});
    @(negedge clk);
    chk("beat_data", {dev_ctrl_in, dev_mod_en, dev_inp}, {1'b1, 1'b0, dec_a[g], data_a[g]});
    rst_at = 0;
    lows = 0;
    seen = 0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) chk("wait_ctrl_in", 300'(dev_ctrl_in), 300'(0));
      if (!dev_resetn) begin
        lows++;
        if (rst_at == 0) rst_at = k;
      end
      if (rsp_valid != '0) begin
        seen = 1;
        break;
      end
    end
    chk("rsp_seen", 300'(seen), 300'(1));
    if (tmo) begin
      chk("abort_start", 300'(rst_at), 300'(TMO + 1));
      chk("abort_len", 300'(lows), 300'(2));
      chk("rsp_latency", 300'(k), 300'(TMO + 3));
    end else begin
      chk("no_abort", 300'(lows), 300'(0));
      chk("rsp_latency", 300'(k), 300'(lat + 2));
    end
    chk("rsp", {rsp_valid, rsp_err, rsp_data}, {oh, tmo, xd});
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_err, rsp_data}, {oh, tmo, xd});
      chk("no_grant_in_resp", 300'(req_ready), 300'(0));
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    chk("rsp_released", 300'(rsp_valid), 300'(0));
  endtask

  initial begin
    int g;
    bit seen;
    resetn = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    dev_mute = 0;
    dev_lat = 1;
    for (int r = 0; r < NREQ; r++) begin
      key_a[r] = '0;
      data_a[r] = '0;
      dec_a[r] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_values");
    resetn = 1'b0;
    model_ptr = 0;

    // Both requesters valid continuously: grants alternate from reset.
    rand_req(0);
    rand_req(1);
    req_valid = '1;
    for (int j = 0; j < 4; j++) run_job($urandom_range(1, 8), 0, 0, 0);
    // Response held off for 10 cycles while the other requester waits.
    run_job($urandom_range(1, 8), 0, 0, 10);
    req_valid = '0;

    // Directed encrypt then decrypt on requester 0.
    key_a[0]  = 256'h0f0e0d0c0b0a09080706050403020100_0f0e0d0c0b0a09080706050403020100;
    data_a[0] = 128'h04000000_03000000_02000000_01000000;
    dec_a[0]  = 1'b0;
    req_valid[0] = 1'b1;
    run_job(3, 0, 1, 0);
    data_a[0] = 128'h7a584d99febc93ead6b3563cc4ad3a63;
    dec_a[0]  = 1'b1;
    req_valid[0] = 1'b1;
    run_job($urandom_range(1, 8), 0, 1, 2);

    // Silent device, then results on the last WAIT cycle and one cycle too late.
    rand_req(1);
    req_valid[1] = 1'b1;
    run_job(0, 1, 1, 0);
    req_valid[1] = 1'b1;
    run_job(TMO - 1, 0, 1, 0);
    req_valid[1] = 1'b1;
    run_job(TMO, 0, 1, 1);

    // Reset in the middle of WAIT drops the job.
    rand_req(0);
    req_valid = 2'b01;
    dev_mute = 1;
    g = exp_grant(req_valid);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready != '0) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_grant_seen", 300'(seen), 300'(1));
    chk("rst_grant", 300'(req_ready), 300'(1 << g));
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midjob_reset_values");
    req_valid = '1;
    #1;
    chk("ready_held_in_reset", 300'(req_ready), 300'(0));
    resetn = 1'b0;
    model_ptr = 0;
    dev_mute = 0;
    rand_req(0);
    rand_req(1);
    run_job($urandom_range(1, 8), 0, 1, 0);
    run_job($urandom_range(1, 8), 0, 1, 0);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
